regs: RTL and testbench

// - Integer register file at the write-back end of the execute-stage result interface (rd_addr/rd_data/reg_wen).
// - Receives one write per cycle from execute and serves two combinational read ports to decode.
// - Read-after-write bypass: decode sees a result in the same cycle execute produces it.
// - Adds a four-phase req/ack debug port for register peek/poke; the core write port always has priority over it.
//

---
 rtl/regs_pkg.sv | 20 ++
 rtl/regs.sv | 119 +++++++++++
 tb/tb_regs.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_pkg.sv
// Shared constants for the integer register file.
//   REG_ADDR_W / REG_DATA_W : default index and data widths
//   REG_NUM                 : number of architectural registers (2**REG_ADDR_W)
//   ZERO_WORD / ZERO_REG    : all-zero data word and the hard-wired x0 index
//   dbg_state_e             : debug handshake FSM states (S_IDLE, S_ACK)
package regs_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_NUM    = 32;

   localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } dbg_state_e;

endpackage

// File: rtl/regs.sv
// Integer register file at the write-back end of execute.
// One core write per cycle, two combinational read ports with same-cycle
// write bypass, and a four-phase req/ack debug port for peek/poke.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reg_wen_i/waddr_i/wdata_i     core write from execute (x0 writes dropped)
//   reg1_raddr_i/reg1_rdata_o     read port 1 (rs1), combinational
//   reg2_raddr_i/reg2_rdata_o     read port 2 (rs2), combinational
//   dbg_req_i/we_i/addr_i/wdata_i debug request, held until ack
//   dbg_ack_o/dbg_rdata_o         registered debug ack and read data
module regs
   import regs_pkg::*;
#(
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int DATA_W  = REG_DATA_W,
   parameter int REG_NUM = regs_pkg::REG_NUM   // must equal 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_wen_i,
   input  logic [ADDR_W-1:0] reg_waddr_i,
   input  logic [DATA_W-1:0] reg_wdata_i,
   input  logic [ADDR_W-1:0] reg1_raddr_i,
   output logic [DATA_W-1:0] reg1_rdata_o,
   input  logic [ADDR_W-1:0] reg2_raddr_i,
   output logic [DATA_W-1:0] reg2_rdata_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              dbg_ack_o,
   output logic [DATA_W-1:0] dbg_rdata_o
);

   logic [DATA_W-1:0] mem [REG_NUM];
   dbg_state_e        state;

   // Read value with x0 forced to zero and the in-flight core write bypassed.
   // Everything is passed in so callers in continuous context stay sensitive
   // to every input.
   function automatic logic [DATA_W-1:0] rd_byp(
      input logic [ADDR_W-1:0] ra,
      input logic              wen,
      input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wd,
      input logic [DATA_W-1:0] stored
   );
      if (ra == ZERO_REG)
         return ZERO_WORD;
      else if (wen && (ra == wa))
         return wd;
      else
         return stored;
   endfunction

   assign reg1_rdata_o = rd_byp(reg1_raddr_i, reg_wen_i, reg_waddr_i, reg_wdata_i,
                                mem[reg1_raddr_i]);
   assign reg2_rdata_o = rd_byp(reg2_raddr_i, reg_wen_i, reg_waddr_i, reg_wdata_i,
                                mem[reg2_raddr_i]);

   // A debug write conflicts with any core write (regardless of index) so the
   // storage only ever sees one writer per edge; debug reads never conflict.
   logic dbg_fire;
   logic core_wr;
   logic dbg_wr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign dbg_fire = (state == S_IDLE) && dbg_req_i && !(dbg_we_i && reg_wen_i);
   assign core_wr  = reg_wen_i && (reg_waddr_i != ZERO_REG);
   assign dbg_wr   = dbg_fire && dbg_we_i && (dbg_addr_i != ZERO_REG);

   assign wr_en   = core_wr || dbg_wr;
   assign wr_addr = core_wr ? reg_waddr_i : dbg_addr_i;
   assign wr_data = core_wr ? reg_wdata_i : dbg_wdata_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++)
            mem[i] <= ZERO_WORD;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Debug handshake: accept only from IDLE, hold ack until req drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         dbg_ack_o   <= 1'b0;
         dbg_rdata_o <= ZERO_WORD;
      end else begin
         case (state)
            S_IDLE: begin
               if (dbg_fire) begin
                  state     <= S_ACK;
                  dbg_ack_o <= 1'b1;
                  // Read sees the same-cycle core write, like the read ports.
                  if (!dbg_we_i)
                     dbg_rdata_o <= rd_byp(dbg_addr_i, reg_wen_i, reg_waddr_i,
                                           reg_wdata_i, mem[dbg_addr_i]);
               end
            end
            S_ACK: begin
               if (!dbg_req_i) begin
                  state     <= S_IDLE;
                  dbg_ack_o <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               dbg_ack_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regs.sv
module tb_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reg_wen_i;
   logic [4:0]  reg_waddr_i;
   logic [31:0] reg_wdata_i;
   logic [4:0]  reg1_raddr_i;
   logic [31:0] reg1_rdata_o;
   logic [4:0]  reg2_raddr_i;
   logic [31:0] reg2_rdata_o;
   logic        dbg_req_i;
   logic        dbg_we_i;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_wdata_i;
   logic        dbg_ack_o;
   logic [31:0] dbg_rdata_o;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regs dut (
      .clk(clk), .rst_n(rst_n),
      .reg_wen_i(reg_wen_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
      .reg1_raddr_i(reg1_raddr_i), .reg1_rdata_o(reg1_rdata_o),
      .reg2_raddr_i(reg2_raddr_i), .reg2_rdata_o(reg2_rdata_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
      .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_reg [32];
   logic        m_ack;
   logic [31:0] m_rdata;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (reg_wen_i && a == reg_waddr_i) return reg_wdata_i;
      return m_reg[a];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
         m_ack   = 1'b0;
         m_rdata = 32'd0;
      end else begin
         logic       dw;
         logic [4:0] da;
         logic [31:0] dd;
         dw = 1'b0; da = dbg_addr_i; dd = dbg_wdata_i;
         if (!m_ack) begin
            if (dbg_req_i && !(dbg_we_i && reg_wen_i)) begin
               m_ack = 1'b1;
               if (dbg_we_i) dw = 1'b1;
               else          m_rdata = m_read(dbg_addr_i);
            end
         end else if (!dbg_req_i) begin
            m_ack = 1'b0;
         end
         if (reg_wen_i && reg_waddr_i != 5'd0) m_reg[reg_waddr_i] = reg_wdata_i;
         if (dw && da != 5'd0) m_reg[da] = dd;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every cycle out of reset: all outputs against the model.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("cmp_rd1",   reg1_rdata_o, m_read(reg1_raddr_i));
         chk("cmp_rd2",   reg2_rdata_o, m_read(reg2_raddr_i));
         chk("cmp_ack",   {31'd0, dbg_ack_o}, {31'd0, m_ack});
         chk("cmp_rdata", dbg_rdata_o, m_rdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic v, input int max, input string nm);
      int n;
      n = 0;
      while (dbg_ack_o !== v && n < max) begin
         step();
         n++;
      end
      checks++;
      if (dbg_ack_o !== v) begin
         errs++;
         $display("FAIL %s: ack timeout, got %b expected %b", nm, dbg_ack_o, v);
      end
   endtask

   task automatic dbg_access(input logic we, input logic [4:0] a, input logic [31:0] d,
                             input string nm);
      dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
      wait_ack(1'b1, 20, nm);
      dbg_req_i = 1'b0;
      wait_ack(1'b0, 20, nm);
   endtask

   initial begin
      rst_n = 1'b0;
      reg_wen_i = 0; reg_waddr_i = 0; reg_wdata_i = 0;
      reg1_raddr_i = 0; reg2_raddr_i = 0;
      dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
      step(); step();
      rst_n = 1'b1;
      step();

      // 1. reset contents, simple write then read
      for (int a = 0; a < 32; a++) begin
         reg1_raddr_i = 5'(a); reg2_raddr_i = 5'(31 - a);
         #1;
         chk("rst_rd1", reg1_rdata_o, 32'd0);
         chk("rst_rd2", reg2_rdata_o, 32'd0);
      end
      chk("rst_ack", {31'd0, dbg_ack_o}, 32'd0);
      chk("rst_rdata", dbg_rdata_o, 32'd0);
      step();
      reg_wen_i = 1; reg_waddr_i = 5; reg_wdata_i = 32'hDEADBEEF;
      step();
      reg_wen_i = 0; reg1_raddr_i = 5;
      #1 chk("wr_x5", reg1_rdata_o, 32'hDEADBEEF);
      step();

      // 2. same-cycle bypass on both ports
      reg_wen_i = 1; reg_waddr_i = 7; reg_wdata_i = 32'h12345678;
      reg1_raddr_i = 7; reg2_raddr_i = 7;
      #1;
      chk("byp_rd1", reg1_rdata_o, 32'h12345678);
      chk("byp_rd2", reg2_rdata_o, 32'h12345678);
      step();
      reg_wen_i = 0;

      // 3. x0 is hard-wired
      reg_wen_i = 1; reg_waddr_i = 0; reg_wdata_i = 32'hFFFFFFFF; reg1_raddr_i = 0;
      #1 chk("x0_byp", reg1_rdata_o, 32'd0);
      step();
      reg_wen_i = 0;
      dbg_access(1'b1, 5'd0, 32'hFFFFFFFF, "x0_dbgwr");
      dbg_access(1'b0, 5'd0, 32'd0, "x0_dbgrd");
      chk("x0_dbg_rdata", dbg_rdata_o, 32'd0);
      reg2_raddr_i = 0;
      #1 chk("x0_rd2", reg2_rdata_o, 32'd0);

      // 4. debug write starved by three core writes
      reg_wen_i = 1; reg_waddr_i = 10; reg_wdata_i = 32'h1010;
      dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 3; dbg_wdata_i = 32'hA5A5A5A5;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("conf_noack", {31'd0, dbg_ack_o}, 32'd0);
      end
      reg_wen_i = 0;
      step();
      chk("conf_ack", {31'd0, dbg_ack_o}, 32'd1);
      dbg_req_i = 0;
      step();
      chk("conf_ackdrop", {31'd0, dbg_ack_o}, 32'd0);
      reg1_raddr_i = 3;
      #1 chk("conf_x3", reg1_rdata_o, 32'hA5A5A5A5);

      // 5. debug read with same-cycle core write to same index
      reg_wen_i = 1; reg_waddr_i = 9; reg_wdata_i = 32'h55;
      dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 9;
      step();
      reg_wen_i = 0;
      chk("rdbyp_ack", {31'd0, dbg_ack_o}, 32'd1);
      chk("rdbyp_data", dbg_rdata_o, 32'h55);
      step(); step();
      chk("rdbyp_hold", {31'd0, dbg_ack_o}, 32'd1);
      chk("rdbyp_hold_d", dbg_rdata_o, 32'h55);
      dbg_req_i = 0;
      step();
      chk("rdbyp_drop", {31'd0, dbg_ack_o}, 32'd0);

      // 6. reset while in ACK
      dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 12; dbg_wdata_i = 32'h77;
      step();
      chk("rst6_ack", {31'd0, dbg_ack_o}, 32'd1);
      rst_n = 0;
      #1;
      chk("rst6_ackclr", {31'd0, dbg_ack_o}, 32'd0);
      reg1_raddr_i = 12; reg2_raddr_i = 5;
      #1;
      chk("rst6_x12", reg1_rdata_o, 32'd0);
      chk("rst6_x5", reg2_rdata_o, 32'd0);
      dbg_req_i = 0;
      step();
      rst_n = 1;
      step();
      dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 12;
      step();
      chk("rst6_newack", {31'd0, dbg_ack_o}, 32'd1);
      chk("rst6_newdata", dbg_rdata_o, 32'd0);
      dbg_req_i = 0;
      wait_ack(1'b0, 5, "rst6_done");

      // random phase, all checking done by the model comparator
      for (int i = 0; i < 3000; i++) begin
         reg_wen_i   = ($urandom_range(1) == 1);
         reg_waddr_i = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
         reg_wdata_i = $urandom;
         reg1_raddr_i = ($urandom_range(3) == 0) ? reg_waddr_i : 5'($urandom);
         reg2_raddr_i = ($urandom_range(3) == 0) ? reg_waddr_i : 5'($urandom);
         if (!dbg_req_i) begin
            if (!dbg_ack_o && $urandom_range(2) == 0) begin
               dbg_req_i   = 1;
               dbg_we_i    = ($urandom_range(1) == 1);
               dbg_addr_i  = ($urandom_range(3) == 0) ? reg_waddr_i : 5'($urandom);
               dbg_wdata_i = $urandom;
            end
         end else if (dbg_ack_o && $urandom_range(1) == 0) begin
            dbg_req_i = 0;
         end
         if (i == 1500) begin
            rst_n = 0;
            #2;
            rst_n = 1;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
